// File: rtl/ika2151_pkg.sv
// ika2151_pkg: shared control-bit layout and counter widths for the YM2151 timer block.
package ika2151_pkg;
  localparam int CTRL_W       = 6;
  localparam int CTRL_LOAD_A  = 0;
  localparam int CTRL_LOAD_B  = 1;
  localparam int CTRL_IRQEN_A = 2;
  localparam int CTRL_IRQEN_B = 3;
  localparam int CTRL_FRST_A  = 4;
  localparam int CTRL_FRST_B  = 5;
  localparam int TA_W         = 10;
  localparam int TB_W         = 8;
  localparam int PRE_W        = 4;
endpackage

// File: rtl/ika2151_timer_counter.sv
// ika2151_timer_counter: load-edge/reload up-counter; ovfl is a one-tick strobe at all-ones.
module ika2151_timer_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             adv,
  input  logic             load,
  input  logic [WIDTH-1:0] n,
  output logic             ovfl
);
  logic [WIDTH-1:0] cnt;
  logic             load_q;

  // a fresh load edge takes priority, so the load tick never advances or overflows
  assign ovfl = tick & adv & load & load_q & (&cnt);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      load_q <= 1'b0;
    end else if (tick) begin
      load_q <= load;
      if (load & ~load_q) cnt <= n;
      else if (load & adv) cnt <= (&cnt) ? n : cnt + 1'b1;
    end
endmodule

// File: rtl/ika2151_timer.sv
// ika2151_timer: YM2151 timers A and B with status flags, overflow pulse and IRQ.
module ika2151_timer
  import ika2151_pkg::*;
(
  input  logic              i_EMUCLK,
  input  logic              i_MRST_n,
  input  logic              i_phi1_PCEN_n,
  input  logic              i_phi1_NCEN_n,
  input  logic              i_CYCLE_31,
  input  logic [7:0]        i_CLKA1,
  input  logic [1:0]        i_CLKA2,
  input  logic [TB_W-1:0]   i_CLKB,
  input  logic [CTRL_W-1:0] i_TIMERCTRL,
  output logic              o_TIMERA_FLAG,
  output logic              o_TIMERB_FLAG,
  output logic              o_TIMERA_OVFL,
  output logic              o_IRQ_n
);
  logic             tick, ovfl_a, ovfl_b, unused_ncen;
  logic [PRE_W-1:0] pre;

  assign unused_ncen = i_phi1_NCEN_n;
  assign tick        = ~i_phi1_PCEN_n & i_CYCLE_31;
  assign o_IRQ_n     = ~(o_TIMERA_FLAG | o_TIMERB_FLAG);

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n)
    if (!i_MRST_n) pre <= '0;
    else if (tick) pre <= pre + 1'b1;

  ika2151_timer_counter #(.WIDTH(TA_W)) u_cnt_a (
    .clk(i_EMUCLK), .rst_n(i_MRST_n), .tick(tick), .adv(1'b1),
    .load(i_TIMERCTRL[CTRL_LOAD_A]), .n({i_CLKA1, i_CLKA2}), .ovfl(ovfl_a)
  );

  // timer B only advances on the prescaler's 15->0 wrap
  ika2151_timer_counter #(.WIDTH(TB_W)) u_cnt_b (
    .clk(i_EMUCLK), .rst_n(i_MRST_n), .tick(tick), .adv(&pre),
    .load(i_TIMERCTRL[CTRL_LOAD_B]), .n(i_CLKB), .ovfl(ovfl_b)
  );

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n)
    if (!i_MRST_n) begin
      o_TIMERA_FLAG <= 1'b0;
      o_TIMERB_FLAG <= 1'b0;
      o_TIMERA_OVFL <= 1'b0;
    end else if (!i_phi1_PCEN_n) begin
      o_TIMERA_FLAG <= ~i_TIMERCTRL[CTRL_FRST_A] & (o_TIMERA_FLAG | (ovfl_a & i_TIMERCTRL[CTRL_IRQEN_A]));
      o_TIMERB_FLAG <= ~i_TIMERCTRL[CTRL_FRST_B] & (o_TIMERB_FLAG | (ovfl_b & i_TIMERCTRL[CTRL_IRQEN_B]));
      if (tick) o_TIMERA_OVFL <= ovfl_a;
    end
endmodule

// File: tb/tb_ika2151_timer.sv
// tb_ika2151_timer: directed vector table plus hand sequences for reset, enable gating and FRST.
module tb_ika2151_timer;
  logic       clk, rst_n, pcen_n, ncen_n, cycle_31;
  logic [9:0] na;
  logic [7:0] nb;
  logic [5:0] ctrl;
  logic       flag_a, flag_b, ovfl, irq_n;
  int         n_cmp, n_bad;

  typedef struct {
    logic [5:0] ctrl;
    logic [9:0] na;
    logic [7:0] nb;
    int         ticks;
    logic       fa, fb, ov, irq;
  } vec_t;
  vec_t v[29];

  ika2151_timer dut (
    .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_phi1_PCEN_n(pcen_n), .i_phi1_NCEN_n(ncen_n),
    .i_CYCLE_31(cycle_31), .i_CLKA1(na[9:2]), .i_CLKA2(na[1:0]), .i_CLKB(nb),
    .i_TIMERCTRL(ctrl), .o_TIMERA_FLAG(flag_a), .o_TIMERB_FLAG(flag_b),
    .o_TIMERA_OVFL(ovfl), .o_IRQ_n(irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic fa, input logic fb, input logic ov, input logic irq);
    chk({tag, " flag_a"}, flag_a, fa);
    chk({tag, " flag_b"}, flag_b, fb);
    chk({tag, " ovfl"}, ovfl, ov);
    chk({tag, " irq_n"}, irq_n, irq);
  endtask

  // each sample is 32 enabled phi1 cycles; returns 1 time unit after the tick edge
  task automatic run_ticks(input int n);
    for (int t = 0; t < n; t++)
      for (int c = 0; c < 32; c++) begin
        cycle_31 = (c == 31);
        @(posedge clk);
        #1;
      end
    cycle_31 = 1'b0;
  endtask

  task automatic apply(input int i);
    ctrl = v[i].ctrl;
    na   = v[i].na;
    nb   = v[i].nb;
    run_ticks(v[i].ticks);
    chk4($sformatf("v%0d", i), v[i].fa, v[i].fb, v[i].ov, v[i].irq);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    // ctrl bits: 01 LOAD_A, 02 LOAD_B, 04 IRQEN_A, 08 IRQEN_B, 10 FRST_A, 20 FRST_B
    v[0]  = '{6'h00, 10'd1020, 8'd0,   2,  1'b0, 1'b0, 1'b0, 1'b1};
    v[1]  = '{6'h01, 10'd1020, 8'd0,   1,  1'b0, 1'b0, 1'b0, 1'b1};
    v[2]  = '{6'h01, 10'd1020, 8'd0,   3,  1'b0, 1'b0, 1'b0, 1'b1};
    v[3]  = '{6'h01, 10'd1020, 8'd0,   1,  1'b0, 1'b0, 1'b1, 1'b1};
    v[4]  = '{6'h01, 10'd1020, 8'd0,   1,  1'b0, 1'b0, 1'b0, 1'b1};
    v[5]  = '{6'h01, 10'd1020, 8'd0,   3,  1'b0, 1'b0, 1'b1, 1'b1};
    v[6]  = '{6'h05, 10'd1023, 8'd0,   1,  1'b0, 1'b0, 1'b0, 1'b1};
    v[7]  = '{6'h05, 10'd1023, 8'd0,   2,  1'b0, 1'b0, 1'b0, 1'b1};
    v[8]  = '{6'h05, 10'd1023, 8'd0,   1,  1'b1, 1'b0, 1'b1, 1'b0};
    v[9]  = '{6'h05, 10'd1023, 8'd0,   1,  1'b1, 1'b0, 1'b1, 1'b0};
    v[10] = '{6'h04, 10'd1023, 8'd0,   3,  1'b1, 1'b0, 1'b0, 1'b0};
    v[11] = '{6'h15, 10'd1023, 8'd0,   1,  1'b0, 1'b0, 1'b0, 1'b1};
    v[12] = '{6'h15, 10'd1023, 8'd0,   1,  1'b0, 1'b0, 1'b1, 1'b1};
    v[13] = '{6'h01, 10'd1023, 8'd0,   1,  1'b0, 1'b0, 1'b1, 1'b1};
    v[14] = '{6'h05, 10'd1023, 8'd0,   1,  1'b1, 1'b0, 1'b1, 1'b0};
    v[15] = '{6'h01, 10'd1023, 8'd0,   1,  1'b1, 1'b0, 1'b1, 1'b0};
    v[16] = '{6'h11, 10'd1023, 8'd0,   1,  1'b0, 1'b0, 1'b1, 1'b1};
    v[17] = '{6'h00, 10'd1023, 8'd0,   1,  1'b0, 1'b0, 1'b0, 1'b1};
    v[18] = '{6'h08, 10'd1023, 8'd255, 1,  1'b0, 1'b0, 1'b0, 1'b1};
    v[19] = '{6'h0A, 10'd1023, 8'd255, 1,  1'b0, 1'b0, 1'b0, 1'b1};
    v[20] = '{6'h0A, 10'd1023, 8'd255, 13, 1'b0, 1'b0, 1'b0, 1'b1};
    v[21] = '{6'h0A, 10'd1023, 8'd255, 1,  1'b0, 1'b1, 1'b0, 1'b0};
    v[22] = '{6'h2A, 10'd1023, 8'd255, 1,  1'b0, 1'b0, 1'b0, 1'b1};
    v[23] = '{6'h0A, 10'd1023, 8'd255, 14, 1'b0, 1'b0, 1'b0, 1'b1};
    v[24] = '{6'h0A, 10'd1023, 8'd255, 1,  1'b0, 1'b1, 1'b0, 1'b0};
    v[25] = '{6'h0F, 10'd1023, 8'd255, 1,  1'b0, 1'b1, 1'b0, 1'b0};
    v[26] = '{6'h0F, 10'd1023, 8'd255, 1,  1'b1, 1'b1, 1'b1, 1'b0};
    v[27] = '{6'h3F, 10'd1023, 8'd255, 1,  1'b0, 1'b0, 1'b1, 1'b1};
    v[28] = '{6'h00, 10'd1023, 8'd255, 16, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b1; pcen_n = 1'b1; ncen_n = 1'b1; cycle_31 = 1'b0;
    ctrl = '0; na = '0; nb = '0;
    #1 rst_n = 1'b0;
    #1 chk4("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1; pcen_n = 1'b0;

    for (int i = 0; i < 18; i++) apply(i);

    // running with flag set, then asynchronous reset between enables
    ctrl = 6'h05; na = 10'd1023;
    run_ticks(2);
    chk4("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    pcen_n = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk4("async_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; pcen_n = 1'b0;

    // prescaler restarts at 0 here, so timer B wraps land on the 16th, 32nd... tick
    for (int i = 18; i < 29; i++) apply(i);

    // ticks without PCEN must not count: LOAD_A edge + overflow would set flag A
    ctrl = 6'h05; pcen_n = 1'b1; cycle_31 = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("gated flag_a", flag_a, 1'b0);
    pcen_n = 1'b0; cycle_31 = 1'b0;
    run_ticks(2);
    chk("ungated flag_a", flag_a, 1'b1);
    chk("ungated irq_n", irq_n, 1'b0);

    // FRST clears on ordinary PCEN cycles, not only at ticks
    ctrl = 6'h15;
    repeat (2) begin @(posedge clk); #1; end
    chk("frst_mid flag_a", flag_a, 1'b0);
    chk("frst_mid irq_n", irq_n, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ika2151_timer.md
IKA2151_TIMER -- requirements
Module: IKA2151_timer

Interface
REQ-001 SHALL provide one clock and an asynchronous active-low reset; all other timing comes from clock enables.
- i_EMUCLK  in  1  emulator master clock; all flops use its rising edge.
- i_MRST_n  in  1  asynchronous active-low master reset.
- i_phi1_PCEN_n  in  1  phi1 positive-edge enable, active low.
- i_phi1_NCEN_n  in  1  phi1 negative-edge enable, active low; accepted but unused.
- i_CYCLE_31  in  1  high during the last phi1 cycle of each 32-cycle sample.
- i_CLKA1  in  8  Timer A value, bits [9:2].
- i_CLKA2  in  2  Timer A value, bits [1:0].
- i_CLKB  in  8  Timer B value.
- i_TIMERCTRL  in  6  levels: [0] LOAD_A, [1] LOAD_B, [2] IRQEN_A, [3] IRQEN_B, [4] FRST_A, [5] FRST_B.
- o_TIMERA_FLAG  out  1  Timer A status flag.
- o_TIMERB_FLAG  out  1  Timer B status flag.
- o_TIMERA_OVFL  out  1  Timer A overflow pulse, consumed by CSM key-on.
- o_IRQ_n  out  1  interrupt request, active low.

Function
REQ-002 SHALL update state only on i_EMUCLK edges where i_phi1_PCEN_n=0; "tick" = PCEN active and i_CYCLE_31=1.
REQ-003 Timer A: 10-bit up-counter CNTA; NA={i_CLKA1,i_CLKA2}.
REQ-004 At a tick where LOAD_A=1 and the previously sampled LOAD_A (sampled at ticks only) =0, CNTA SHALL load NA; no increment that tick.
REQ-005 At a tick where LOAD_A is still 1 and CNTA/=1023, CNTA SHALL increment by 1.
REQ-006 At a tick where LOAD_A is still 1 and CNTA=1023, CNTA SHALL reload NA (overflow A); period = 1024-NA ticks.
REQ-007 LOAD_A=0 SHALL freeze CNTA; NA changes while running take effect at the next reload only.
REQ-008 Timer B SHALL be an 8-bit counter CNTB with a free-running 4-bit prescaler PRE.
- PRE increments every tick regardless of LOAD_B.
- CNTB follows REQ-004..007 rules (with NB, LOAD_B), but load is evaluated each tick and increment/overflow only at ticks where PRE wraps 15->0.
- Overflow at CNTB=255; period 16*(256-NB) ticks; first period may be shorter by PRE phase.
REQ-009 o_TIMERA_OVFL SHALL be set at an overflow-A tick and cleared at the next tick: exactly 32 phi1 cycles high; independent of IRQEN_A.
REQ-010 A flag SHALL be set on its overflow tick only if its IRQEN bit=1 at that tick.
REQ-011 FRSTx=1 SHALL clear flag x on every PCEN cycle; clear beats a simultaneous set.
REQ-012 Clearing IRQENx SHALL NOT clear an already-set flag.
REQ-013 o_IRQ_n SHALL be ~(o_TIMERA_FLAG | o_TIMERB_FLAG), combinational from the flag flops.
REQ-014 Flags and o_TIMERA_OVFL SHALL be registered outputs; latency from overflow tick to output = same PCEN edge.

Reset
REQ-015 Reset SHALL clear CNTA, CNTB, PRE, load-history bits, both flags and o_TIMERA_OVFL; o_IRQ_n=1.
REQ-016 Reset asserted mid-count SHALL take effect immediately without waiting for a clock enable; counting resumes only via a new LOAD 0->1 edge after release.

Structure
REQ-017 TIMERCTRL bit indices and widths (10, 8, 4) SHALL live in the shared IKA2151 package/defines.
REQ-018 One sub-module IKA2151_timer_counter (parameter WIDTH; load-edge, freeze, reload, overflow) SHALL be instantiated for A (WIDTH=10) and B (WIDTH=8, advance gated by PRE wrap).

Verification
REQ-019 NA=1023, LOAD_A 0->1, IRQEN_A=1 -> overflow every tick; flag A set one tick after load; o_IRQ_n=0.
REQ-020 NA=1020, IRQEN_A=0 -> o_TIMERA_OVFL high 32 cycles every 128 phi1 cycles; flag A stays 0; o_IRQ_n=1.
REQ-021 NB=255, LOAD_B=1, IRQEN_B=1 -> flag B set; subsequent overflows every 16 ticks (512 phi1 cycles).
REQ-022 FRST_A=1 during the overflow tick -> flag A remains 0; o_TIMERA_OVFL still pulses.
REQ-023 Counter running with flags set, assert i_MRST_n=0 between enables -> all outputs reset immediately; o_IRQ_n=1; no counting until LOAD re-edge.
